// File: rtl/ws2812_chain_driver_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 chain driver.
//   - frame geometry (LED count, bits per LED, bits per frame)
//   - frame FSM state encoding
//   - RGB -> GRB transmit-word reorder helper
package ws2812_pkg;

    localparam int NUM_LEDS     = 4;
    localparam int BITS_PER_LED = 24;
    localparam int FRAME_BITS   = NUM_LEDS * BITS_PER_LED;

    localparam logic [2:0] ST_LATCH = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_LOW   = 3'd4;

    typedef enum logic [2:0] {
        S_LATCH = ST_LATCH,
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_HIGH  = ST_HIGH,
        S_LOW   = ST_LOW
    } state_e;

    // [0:7]=R, [8:15]=G, [16:23]=B in; G, R, B out, index 0 sent first.
    function automatic logic [0:23] grb_word(input logic [0:23] rgb);
        return {rgb[8:15], rgb[0:7], rgb[16:23]};
    endfunction

endpackage

// File: rtl/ws2812_chain_driver_if.sv
// ws2812_chain_driver_if: control/colour inputs and serial/status outputs
// of the chain driver.
//   enable             1 = keep refreshing, 0 = stop after current frame
//   led1_rgb..led4_rgb [0:23] colour words, R/G/B bytes
//   dout               serial NRZ data to the LED chain
//   busy               high from LOAD through the last bit's low phase
//   frame_done         one-cycle pulse at the end of a frame
// master drives enable/colours, slave (the driver) drives the outputs.
interface ws2812_chain_driver_if;

    logic        enable;
    logic [0:23] led1_rgb;
    logic [0:23] led2_rgb;
    logic [0:23] led3_rgb;
    logic [0:23] led4_rgb;
    logic        dout;
    logic        busy;
    logic        frame_done;

    modport master (
        output enable, led1_rgb, led2_rgb, led3_rgb, led4_rgb,
        input  dout, busy, frame_done
    );

    modport slave (
        input  enable, led1_rgb, led2_rgb, led3_rgb, led4_rgb,
        output dout, busy, frame_done
    );

endinterface

// File: rtl/ws2812_chain_driver_bit_timer.sv
// ws2812_bit_timer: generates one WS2812 bit cell on a registered output.
//   clk, reset  clock, async active-high reset
//   start       begin a bit cell; dout rises on the following cycle
//   bit_val     value of the bit; sampled at start and again at the end of
//               the high phase, so it must be held for the whole high phase
//   dout        serial output, high T0H/T1H cycles then low for the rest
//               of a BIT_CYC cell
//   high_done   last cycle of the high phase
//   bit_done    last cycle of the low phase (start may be raised here to
//               run cells back to back)
module ws2812_bit_timer #(
    parameter int T0H_CYC = 20,
    parameter int T1H_CYC = 40,
    parameter int BIT_CYC = 63
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic dout,
    output logic high_done,
    output logic bit_done
);

    localparam int CW = $clog2(BIT_CYC + 1);

    localparam logic [CW-1:0] T0H_L = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_L = CW'(T1H_CYC);
    localparam logic [CW-1:0] T0L_L = CW'(BIT_CYC - T0H_CYC);
    localparam logic [CW-1:0] T1L_L = CW'(BIT_CYC - T1H_CYC);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] cnt;
    logic          low_phase;

    assign high_done = dout && (cnt == ONE);
    assign bit_done  = low_phase && (cnt == ONE);

    // The counter holds at 1 when a phase ends; every reload is >= 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout      <= 1'b0;
            low_phase <= 1'b0;
            cnt       <= '0;
        end else if (start) begin
            dout      <= 1'b1;
            low_phase <= 1'b0;
            cnt       <= bit_val ? T1H_L : T0H_L;
        end else if (dout) begin
            if (high_done) begin
                dout      <= 1'b0;
                low_phase <= 1'b1;
                cnt       <= bit_val ? T1L_L : T0L_L;
            end else begin
                cnt <= cnt - ONE;
            end
        end else if (low_phase) begin
            if (bit_done) begin
                low_phase <= 1'b0;
            end else begin
                cnt <= cnt - ONE;
            end
        end
    end

endmodule

// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver: continuously refreshes a 4-LED WS2812 chain.
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    slave side of ws2812_chain_driver_if (enable, led1..4_rgb in;
//          dout, busy, frame_done out)
// Each frame snapshots the four colour words in LOAD and sends 96 bits,
// GRB order, MSB first, LED1 first, followed by a full latch gap.
module ws2812_chain_driver
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC   = 20,
    parameter int T1H_CYC   = 40,
    parameter int BIT_CYC   = 63,
    parameter int LATCH_CYC = 15000
) (
    input  logic                 clk,
    input  logic                 reset,
    ws2812_chain_driver_if.slave bus
);

    localparam int LW = $clog2(LATCH_CYC + 1);
    localparam int IW = $clog2(FRAME_BITS);

    localparam logic [LW-1:0] LATCH_L  = LW'(LATCH_CYC);
    localparam logic [LW-1:0] LATCH_1  = LW'(1);
    localparam logic [IW-1:0] LAST_BIT = IW'(FRAME_BITS - 1);

    state_e                  state;
    logic [LW-1:0]           latch_cnt;
    logic [0:FRAME_BITS-1]   sr;
    logic [IW-1:0]           bit_idx;
    logic                    busy_q;
    logic                    done_q;

    logic [0:FRAME_BITS-1]   frame_word;
    logic                    start;
    logic                    bit_val;
    logic                    tx_dout;
    logic                    high_done;
    logic                    bit_done;

    assign frame_word = {grb_word(bus.led1_rgb), grb_word(bus.led2_rgb),
                         grb_word(bus.led3_rgb), grb_word(bus.led4_rgb)};

    assign start = (state == S_LOAD) ||
                   ((state == S_LOW) && bit_done && (bit_idx != LAST_BIT));

    // The timer needs the value of the bit it is about to start: in LOAD
    // that is still on the inputs, at a bit boundary it is the next one
    // in the shift register, and during HIGH it is the current one.
    always_comb begin
        bit_val = sr[0];
        if (state == S_LOAD) begin
            bit_val = frame_word[0];
        end else if (start) begin
            bit_val = sr[1];
        end
    end

    ws2812_bit_timer #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bit_val   (bit_val),
        .dout      (tx_dout),
        .high_done (high_done),
        .bit_done  (bit_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_LATCH;
            latch_cnt <= LATCH_L;
            sr        <= '0;
            bit_idx   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_LATCH: begin
                    if (latch_cnt == LATCH_1) begin
                        state  <= bus.enable ? S_LOAD : S_IDLE;
                        busy_q <= bus.enable;
                    end else begin
                        latch_cnt <= latch_cnt - LATCH_1;
                    end
                end
                S_IDLE: begin
                    if (bus.enable) begin
                        state  <= S_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    sr      <= frame_word;
                    bit_idx <= '0;
                    state   <= S_HIGH;
                end
                S_HIGH: begin
                    if (high_done) begin
                        state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_BIT) begin
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            latch_cnt <= LATCH_L;
                            state     <= S_LATCH;
                        end else begin
                            sr      <= {sr[1:FRAME_BITS-1], 1'b0};
                            bit_idx <= bit_idx + IW'(1);
                            state   <= S_HIGH;
                        end
                    end
                end
                default: begin
                    state     <= S_LATCH;
                    latch_cnt <= LATCH_L;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout       = tx_dout;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// tb_ws2812_chain_driver: directed bench for ws2812_chain_driver.
// Bit timing is left at its defaults; the latch gap is shortened to keep
// the run short. Expected frames are hand-written 96-bit constants, bit 0
// in the MSB.
module tb_ws2812_chain_driver;

    localparam int LATCH     = 3000;
    localparam int FRAME_CYC = 6049;

    localparam logic [95:0] F_LED1_R = 96'h00FF00_000000_000000_000000;
    localparam logic [95:0] F_LED4_B = 96'h000000_000000_000000_0000A5;
    localparam logic [95:0] F_ZERO   = 96'h0;
    localparam logic [95:0] F_LED2_G = 96'h000000_FF0000_000000_000000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ws2812_chain_driver_if bus();

    ws2812_chain_driver #(
        .T0H_CYC   (20),
        .T1H_CYC   (40),
        .BIT_CYC   (63),
        .LATCH_CYC (LATCH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passes = 0;
    int total  = 0;
    int cyc    = 0;
    int c0     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Called on the first high sample of a bit; returns its high and low
    // lengths in cycles and leaves the bench on the sample after the bit.
    task automatic get_bit(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (bus.dout === 1'b1 && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        while (bus.dout === 1'b0 && bus.busy === 1'b1 && lo < 200) begin
            lo++;
            @(negedge clk);
        end
    endtask

    task automatic check_bits(input int f, input logic [95:0] exp,
                              input int first, input int last);
        int   hi;
        int   lo;
        logic b;
        for (int i = first; i <= last; i++) begin
            get_bit(hi, lo);
            b = exp[95-i];
            check($sformatf("f%0d bit%0d high", f, i), hi, b ? 40 : 20);
            check($sformatf("f%0d bit%0d low", f, i), lo, b ? 23 : 43);
        end
    endtask

    // Called on the LOAD sample.
    task automatic start_frame(input int f);
        check($sformatf("f%0d load busy", f), int'(bus.busy), 1);
        check($sformatf("f%0d load dout", f), int'(bus.dout), 0);
        c0 = cyc;
        @(negedge clk);
        check($sformatf("f%0d first rise", f), int'(bus.dout), 1);
    endtask

    // Called on the sample right after the last bit's low phase.
    task automatic finish_frame(input int f);
        check($sformatf("f%0d frame_done", f), int'(bus.frame_done), 1);
        check($sformatf("f%0d busy end", f), int'(bus.busy), 0);
        check($sformatf("f%0d frame length", f), cyc - c0, FRAME_CYC);
    endtask

    // Counts low, not-busy samples from the current one until busy rises.
    task automatic latch_gap(input string tag, input int exp_pulses);
        int n;
        int bad;
        int pulses;
        n = 0;
        bad = 0;
        pulses = 0;
        while (bus.busy !== 1'b1 && n < LATCH + 500) begin
            n++;
            if (bus.dout !== 1'b0) bad++;
            if (bus.frame_done === 1'b1) pulses++;
            @(negedge clk);
        end
        check({tag, " length"}, n, LATCH);
        check({tag, " dout high"}, bad, 0);
        check({tag, " done pulses"}, pulses, exp_pulses);
    endtask

    initial begin
        int bad;
        int busyn;
        int pulses;

        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.led1_rgb = 24'hFF0000;
        bus.led2_rgb = 24'h0;
        bus.led3_rgb = 24'h0;
        bus.led4_rgb = 24'h0;

        repeat (3) @(negedge clk);
        check("reset dout", int'(bus.dout), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset frame_done", int'(bus.frame_done), 0);
        reset = 1'b0;
        latch_gap("reset gap", 0);

        // Frame 1: LED1 red -> G byte zeros, R byte ones.
        start_frame(1);
        check_bits(1, F_LED1_R, 0, 95);
        finish_frame(1);
        bus.led1_rgb = 24'h0;
        bus.led4_rgb = 24'h0000A5;
        latch_gap("gap1", 1);

        // Frame 2: LED4 blue A5 in the last byte.
        start_frame(2);
        check_bits(2, F_LED4_B, 0, 95);
        finish_frame(2);
        bus.led4_rgb = 24'h0;
        latch_gap("gap2", 1);

        // Frame 3: LED2 written mid-frame, must not show until frame 4.
        start_frame(3);
        check_bits(3, F_ZERO, 0, 9);
        bus.led2_rgb = 24'h00FF00;
        check_bits(3, F_ZERO, 10, 95);
        finish_frame(3);
        latch_gap("gap3", 1);

        // Frame 4: enable dropped at bit 50, frame still completes.
        start_frame(4);
        check_bits(4, F_LED2_G, 0, 49);
        bus.enable = 1'b0;
        check_bits(4, F_LED2_G, 50, 95);
        finish_frame(4);

        bad = 0;
        busyn = 0;
        pulses = 0;
        repeat (LATCH + 100) begin
            if (bus.dout !== 1'b0) bad++;
            if (bus.busy !== 1'b0) busyn++;
            if (bus.frame_done === 1'b1) pulses++;
            @(negedge clk);
        end
        check("idle dout high", bad, 0);
        check("idle busy", busyn, 0);
        check("idle done pulses", pulses, 1);

        // Reassert from IDLE: LOAD on the next cycle.
        bus.enable = 1'b1;
        @(negedge clk);
        start_frame(5);
        check_bits(5, F_LED2_G, 0, 29);

        // Reset during the high phase of bit 30.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset dout", int'(bus.dout), 0);
        check("async reset busy", int'(bus.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        latch_gap("post-reset gap", 0);

        start_frame(6);
        check_bits(6, F_LED2_G, 0, 95);
        finish_frame(6);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
